// File: rtl/port_input_conditioner.sv
// port_input_conditioner
//
// Conditions raw external pins before they reach the drf_system port_input.
// Each bit is synchronized through two flops and then debounced by its own
// counter.  The accepted level is clean_out.  Registered edge pulses and
// sticky rising-edge event flags are derived from clean_out.
//
// Ports:
//   clk         system clock (same clock as drf_system)
//   rst_n       asynchronous active-low reset
//   raw_in      asynchronous external pins
//   event_clr   per-bit clear strobe for event_flag
//   clean_out   debounced level, drives port_input
//   rise_pulse  one-cycle pulse on a clean_out 0->1 transition
//   fall_pulse  one-cycle pulse on a clean_out 1->0 transition
//   event_flag  sticky rise flag; set wins over a simultaneous clear

module port_input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [WIDTH-1:0] event_clr,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] event_flag
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] rise_q,  rise_d;
    logic [WIDTH-1:0] fall_q,  fall_d;
    logic [WIDTH-1:0] flag_q,  flag_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        clean_d = clean_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    clean_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // Pulses are computed from the level being registered this edge so
        // they line up with the clean_out update.
        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;
        // A rise registered this edge overrides a simultaneous clear.
        flag_d = rise_d | (flag_q & ~event_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            flag_q  <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            flag_q  <= flag_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign event_flag = flag_q;

endmodule

// File: tb/tb_port_input_conditioner.sv
module tb_port_input_conditioner;

    typedef struct {
        int         idx;
        logic [3:0] raw;
        logic [3:0] clr;
        logic [3:0] clean;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] flag;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] raw_in = '0;
    logic [3:0] event_clr = '0;
    logic [3:0] clean_out, rise_pulse, fall_pulse, event_flag;

    int total = 0;
    int bad = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    port_input_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .event_clr  (event_clr),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .event_flag (event_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step%0d got=%b want=%b", name, idx, got, want);
        end
    endtask

    task automatic add(input int n, input logic [3:0] raw, input logic [3:0] clr,
                       input logic [3:0] clean, input logic [3:0] rise,
                       input logic [3:0] fall, input logic [3:0] flag);
        for (int j = 0; j < n; j++) begin
            vec_t v;
            v.idx = tbl.size();
            v.raw = raw; v.clr = clr; v.clean = clean;
            v.rise = rise; v.fall = fall; v.flag = flag;
            tbl.push_back(v);
        end
    endtask

    // Drive at negedge and queue the expectation for the following posedge.
    task automatic drive(input vec_t v);
        raw_in    = v.raw;
        event_clr = v.clr;
        exp_q.push_back(v);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            chk("clean_out",  e.idx, clean_out,  e.clean);
            chk("rise_pulse", e.idx, rise_pulse, e.rise);
            chk("fall_pulse", e.idx, fall_pulse, e.fall);
            chk("event_flag", e.idx, event_flag, e.flag);
        end
    end

    initial begin
        vec_t v;
        // raw, clr, clean, rise, fall, flag  (DEBOUNCE_CYCLES=4: latency 5 steps)
        add(3, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // bit1 glitch starts
        add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // bit1 drops
        add(1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // bit1 restarts
        add(1, 4'b0011, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001); // bit0 rise
        add(3, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        add(1, 4'b0011, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 4'b0011); // bit1 full latency
        add(5, 4'b0111, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
        add(1, 4'b0111, 4'b0000, 4'b0111, 4'b0100, 4'b0000, 4'b0111); // bit2 rise
        add(1, 4'b0111, 4'b0100, 4'b0111, 4'b0000, 4'b0000, 4'b0011); // clear bit2
        add(5, 4'b0011, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0011);
        add(1, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0100, 4'b0011); // bit2 fall
        add(3, 4'b1011, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
        add(2, 4'b1011, 4'b1000, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
        add(1, 4'b1011, 4'b1000, 4'b1011, 4'b1000, 4'b0000, 4'b1011); // set beats clear
        add(1, 4'b1011, 4'b1000, 4'b1011, 4'b0000, 4'b0000, 4'b0011); // held clear
        add(1, 4'b0010, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0011); // bits 0,3 drop
        add(1, 4'b1010, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0011); // bit3 bounce
        add(3, 4'b0010, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0011);
        add(1, 4'b0010, 4'b0000, 4'b1010, 4'b0000, 4'b0001, 4'b0011); // bit0 nominal
        add(1, 4'b0010, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b0011);
        add(1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0011); // bit3 later
        add(2, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0011);

        // Reset state
        #12;
        chk("rst_clean", -1, clean_out,  4'b0000);
        chk("rst_rise",  -1, rise_pulse, 4'b0000);
        chk("rst_fall",  -1, fall_pulse, 4'b0000);
        chk("rst_flag",  -1, event_flag, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i]);
        end

        // Async reset while the counters of bits 0,2,3 sit at 2.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v.idx = 100 + i; v.raw = 4'hF; v.clr = 4'h0;
            v.clean = 4'b0010; v.rise = '0; v.fall = '0; v.flag = 4'b0011;
            drive(v);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clean", 200, clean_out,  4'b0000);
        chk("async_rise",  200, rise_pulse, 4'b0000);
        chk("async_fall",  200, fall_pulse, 4'b0000);
        chk("async_flag",  200, event_flag, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            if (e > 1) @(negedge clk);
            v.idx = 300 + e; v.raw = 4'hF; v.clr = 4'h0; v.fall = '0;
            v.clean = (e >= 6) ? 4'hF : 4'h0;
            v.rise  = (e == 6) ? 4'hF : 4'h0;
            v.flag  = (e >= 6) ? 4'hF : 4'h0;
            drive(v);
        end

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/port_input_conditioner.md
# port_input_conditioner

Conditions the raw external input pins before they reach the `drf_system` 4-bit `port_input`. Each bit passes through a two-flop synchronizer and a per-bit debounce counter, which together produce a glitch-free `clean_out` that drives `port_input` directly. The block also produces one-cycle edge pulses and sticky rising-edge event flags with a clear handshake, for polling logic or a future interrupt source.

## Interface
- `WIDTH`, default 4: number of independent input bits. Must match the `port_input` width.
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronized cycles a new level must hold before it is accepted. Minimum 2. The counter width is `$clog2(DEBOUNCE_CYCLES)`.

Ports:
- `clk`  in  1: system clock, the same clock as `drf_system`.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `raw_in`  in  WIDTH: asynchronous external pins.
- `event_clr`  in  WIDTH: per-bit clear strobe for `event_flag`, sampled on `clk`.
- `clean_out`  out  WIDTH: debounced level; drives `port_input`.
- `rise_pulse`  out  WIDTH: one-cycle pulse when a `clean_out` bit goes 0→1.
- `fall_pulse`  out  WIDTH: one-cycle pulse when a `clean_out` bit goes 1→0.
- `event_flag`  out  WIDTH: sticky per-bit flag, set by `rise_pulse` and cleared by `event_clr`.

## Operation
- Every bit is fully independent and has its own `sync1`, `sync2`, `cnt`, `clean`, pulse and flag registers.
- Reset (`rst_n`=0, asynchronous):
  - `sync1`, `sync2`, `cnt`, `clean_out`, `rise_pulse`, `fall_pulse` and `event_flag` all go to 0 immediately.
  - Reset dominates all other inputs.
- Synchronizer:
  - `sync1` <= `raw_in`.
  - `sync2` <= `sync1`.
  - Only `sync2` is used downstream. `raw_in` is never read combinationally.
- Debounce, per bit, on each rising edge of `clk`:
  - If `sync2 == clean`: `cnt` <= 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `clean` <= `sync2` and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
- A mismatch that ends before the count completes (a glitch or bounce) resets `cnt` to 0. Partial counts are never carried over.
- Edge pulses:
  - `rise_pulse` and `fall_pulse` are registered on the same edge that updates `clean`.
  - Each is high for exactly one cycle.
  - For a given bit they are never high together.
- Event flag, per bit, evaluated in priority order:
  - `rise_pulse` asserted on this update → flag set to 1. Set wins over a simultaneous `event_clr`.
  - Otherwise, `event_clr`=1 → flag cleared to 0.
  - Otherwise the flag holds.
- `event_clr` held high keeps the flag clear except in the cycle a new rise is registered.
- `fall_pulse` has no effect on `event_flag`.
- The counter never wraps: it is bounded at `DEBOUNCE_CYCLES-1` by construction.

## Timing
- Let edge k be the first `clk` edge at which `sync1` captures a new `raw_in` level, with the level then held steady:
  - `sync2` shows the new level after edge k+1.
  - `clean_out` and the matching pulse update at edge k+1+`DEBOUNCE_CYCLES`.
  - The pulse drops at edge k+2+`DEBOUNCE_CYCLES`.
- With the default `DEBOUNCE_CYCLES`=16, latency is 17 edges after capture.
- `event_flag` rises on the same edge as `rise_pulse`.
- `event_clr` takes effect on the edge it is sampled, so the flag reads 0 in the next cycle.
- Reset release mid-count:
  - All state restarts from 0.
  - A pin held high through reset is re-debounced and produces a `rise_pulse` `DEBOUNCE_CYCLES`+2 edges after release.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Clean rise** (`DEBOUNCE_CYCLES`=4): `raw_in[0]` 0→1, captured at edge k → `clean_out[0]`=1 and `rise_pulse[0]`=1 at edge k+5; the pulse is 0 again at k+6; `event_flag[0]`=1.
- **Glitch rejection**: `raw_in[1]` high for 3 cycles, then low → `clean_out[1]` stays 0 and no pulse occurs. Then hold it high for 4+ cycles → the rise is accepted with full latency, confirming `cnt` restarted.
- **Fall and clear**: after a rise on bit 2, pulse `event_clr[2]` → `event_flag[2]`=0 next cycle. Drop `raw_in[2]` → `fall_pulse[2]` one cycle; `event_flag[2]` stays 0.
- **Set/clear collision**: assert `event_clr[3]` on the exact cycle `rise_pulse[3]` is registered → `event_flag[3]`=1.
- **Async reset mid-count**: assert `rst_n`=0 while `cnt`=2 with `raw_in`=4'hF held → all outputs are 0 immediately. After release, `clean_out`=4'hF and `rise_pulse`=4'hF at edge 6 after release (`DEBOUNCE_CYCLES`=4).
- **Independence**: change bits 0 and 3 together, with bounce injected only on bit 3 → bit 0 updates at nominal latency and bit 3 updates only after its own stable window.
